// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: issues one FP ALU operation at a time, holds the front end
// of the pipeline for the op's fixed latency, then pulses the matching
// register-file write enable on the cycle the FP ALU result is valid.
//
// Optional build macro: FPSEQ_PERF_CNT_EN adds the oOpCount / oStallCycles
// performance counters. Without it those ports and counters do not exist.
//
// FP ALU codes follow the core's Parametros.v numbering for the multi-cycle
// ops; every other code (sign-inject, min/max, compare, cvt, mv, FPOPNULL)
// takes the single-cycle LAT_SIMPLE path.
module fp_op_sequencer #(
    parameter int LAT_ADDSUB = 4,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 10,
    parameter int LAT_SQRT   = 12,
    parameter int LAT_SIMPLE = 1,
    parameter int CNT_W      = 5
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic [4:0] iFPALUControl,
    input  logic [4:0] iRd,
    input  logic       iWriteFP,
    input  logic       iWriteInt,
    output logic       oStall,
    output logic       oFPUStart,
    output logic [4:0] oFPUOp,
    output logic       oFPRegWrite,
    output logic       oRegWrite,
    output logic [4:0] oWbRd,
    output logic       oBusy
`ifdef FPSEQ_PERF_CNT_EN
    ,
    output logic [31:0] oOpCount,
    output logic [31:0] oStallCycles
`endif
);

    // FP ALU codes that carry a multi-cycle latency
    localparam logic [4:0] FOPADD  = 5'd0;
    localparam logic [4:0] FOPSUB  = 5'd1;
    localparam logic [4:0] FOPMUL  = 5'd2;
    localparam logic [4:0] FOPDIV  = 5'd3;
    localparam logic [4:0] FOPSQRT = 5'd4;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       op_q;
    logic [4:0]       rd_q;
    logic             wfp_q;
    logic             wint_q;
    logic [CNT_W-1:0] lat_d;

    // Latency of an FP ALU code in cycles; a zero latency parameter is
    // treated as one so the FSM always passes through DONE.
    function automatic logic [CNT_W-1:0] lat_sel(input logic [4:0] op);
        int lat;
        case (op)
            FOPADD, FOPSUB: lat = LAT_ADDSUB;
            FOPMUL:         lat = LAT_MUL;
            FOPDIV:         lat = LAT_DIV;
            FOPSQRT:        lat = LAT_SQRT;
            default:        lat = LAT_SIMPLE;
        endcase
        return (lat < 1) ? CNT_ONE : lat[CNT_W-1:0];
    endfunction

    // Latency lookup for the op latched in IDLE
    always_comb begin
        lat_d = lat_sel(op_q);
    end

    // Sequencer FSM: latch the instruction, issue, count latency, write back
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= 5'd0;
            rd_q    <= 5'd0;
            wfp_q   <= 1'b0;
            wint_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        op_q    <= iFPALUControl;
                        rd_q    <= iRd;
                        wfp_q   <= iWriteFP;
                        wint_q  <= iWriteInt;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (lat_d == CNT_ONE) begin
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= lat_d - CNT_ONE;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    // <= also guards against a corrupted zero count hanging here
                    if (cnt_q <= CNT_ONE) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Same instruction is still presented here; do not re-accept it
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall starts combinationally in IDLE so the instruction holds from its first cycle
    assign oStall      = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                         ((state_q == S_IDLE) && iStart);
    assign oFPUStart   = (state_q == S_ISSUE);
    assign oFPRegWrite = (state_q == S_DONE) && wfp_q;
    assign oRegWrite   = (state_q == S_DONE) && wint_q;
    assign oBusy       = (state_q != S_IDLE);
    assign oFPUOp      = op_q;
    assign oWbRd       = rd_q;

`ifdef FPSEQ_PERF_CNT_EN
    logic [31:0] op_count_q;
    logic [31:0] stall_cycles_q;

    // Performance counters: issued ops and stalled cycles, wrapping mod 2**32
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            op_count_q     <= 32'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            if (state_q == S_ISSUE) begin
                op_count_q <= op_count_q + 32'd1;
            end
            if (oStall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign oOpCount     = op_count_q;
    assign oStallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Directed bench for fp_op_sequencer: a per-cycle vector table for the
// basic op shapes, then hand-written sequences for held iStart, reset
// abort and (when FPSEQ_PERF_CNT_EN is defined) the performance counters.
module tb_fp_op_sequencer;

    localparam logic [4:0] FOPADD   = 5'd0;
    localparam logic [4:0] FOPMUL   = 5'd2;
    localparam logic [4:0] FOPDIV   = 5'd3;
    localparam logic [4:0] FOPSQRT  = 5'd4;
    localparam logic [4:0] FOPSGNJS = 5'd7;
    localparam logic [4:0] FOPCLT   = 5'd11;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iStart = 1'b0;
    logic [4:0] iFPALUControl = 5'd0;
    logic [4:0] iRd = 5'd0;
    logic       iWriteFP = 1'b0;
    logic       iWriteInt = 1'b0;
    logic       oStall, oFPUStart, oFPRegWrite, oRegWrite, oBusy;
    logic [4:0] oFPUOp, oWbRd;
`ifdef FPSEQ_PERF_CNT_EN
    logic [31:0] oOpCount, oStallCycles;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    fp_op_sequencer dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iStart        (iStart),
        .iFPALUControl (iFPALUControl),
        .iRd           (iRd),
        .iWriteFP      (iWriteFP),
        .iWriteInt     (iWriteInt),
        .oStall        (oStall),
        .oFPUStart     (oFPUStart),
        .oFPUOp        (oFPUOp),
        .oFPRegWrite   (oFPRegWrite),
        .oRegWrite     (oRegWrite),
        .oWbRd         (oWbRd),
        .oBusy         (oBusy)
`ifdef FPSEQ_PERF_CNT_EN
        ,
        .oOpCount      (oOpCount),
        .oStallCycles  (oStallCycles)
`endif
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        rst;
        logic        st;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        wfp;
        logic        wint;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected output word {stall, fpustart, fpwrite, intwrite, busy, op, rd}
    function automatic logic [14:0] E(input logic s, input logic st, input logic fw,
                                      input logic rw, input logic b,
                                      input logic [4:0] op, input logic [4:0] rd);
        return {s, st, fw, rw, b, op, rd};
    endfunction

    function automatic logic [14:0] outs();
        return {oStall, oFPUStart, oFPRegWrite, oRegWrite, oBusy, oFPUOp, oWbRd};
    endfunction

    task automatic addv(input logic rst, input logic st, input logic [4:0] op,
                        input logic [4:0] rd, input logic wfp, input logic wint,
                        input logic [14:0] exp);
        vec_t v;
        v.rst = rst; v.st = st; v.op = op; v.rd = rd; v.wfp = wfp; v.wint = wint; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One cycle: drive inputs just after the rising edge, sample at the falling edge
    task automatic cyc(input logic rst, input logic st, input logic [4:0] op,
                       input logic [4:0] rd, input logic wfp, input logic wint);
        @(posedge iCLK);
        #1;
        iRST = rst; iStart = st; iFPALUControl = op; iRd = rd;
        iWriteFP = wfp; iWriteInt = wint;
        @(negedge iCLK);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    initial begin
        int writes;

        // Reset state
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 0, 0, 0, 5'd0, 5'd0));
        // FOPADD rd=3 FP write: stall c0..c4, issue c1, write c5
        addv(0, 1, FOPADD, 5'd3, 1, 0, E(1, 0, 0, 0, 0, 5'd0, 5'd0));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 1, 0, 0, 1, FOPADD, 5'd3));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 0, 0, 0, 1, FOPADD, 5'd3));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 0, 0, 0, 1, FOPADD, 5'd3));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 0, 0, 0, 1, FOPADD, 5'd3));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 1, 0, 1, FOPADD, 5'd3));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 0, 0, 0, FOPADD, 5'd3));
        // FOPSGNJS (L=1) rd=9: stall c0..c1, issue c1, write c2
        addv(0, 1, FOPSGNJS, 5'd9, 1, 0, E(1, 0, 0, 0, 0, FOPADD, 5'd3));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 1, 0, 0, 1, FOPSGNJS, 5'd9));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 1, 0, 1, FOPSGNJS, 5'd9));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 0, 0, 0, FOPSGNJS, 5'd9));
        // FOPCLT rd=7 integer write only: oRegWrite at c2
        addv(0, 1, FOPCLT, 5'd7, 0, 1, E(1, 0, 0, 0, 0, FOPSGNJS, 5'd9));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 1, 0, 0, 1, FOPCLT, 5'd7));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 0, 1, 1, FOPCLT, 5'd7));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 0, 0, 0, FOPCLT, 5'd7));
        // FOPMUL (L=3) rd=31 with both write flags: both enables at c4
        addv(0, 1, FOPMUL, 5'd31, 1, 1, E(1, 0, 0, 0, 0, FOPCLT, 5'd7));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 1, 0, 0, 1, FOPMUL, 5'd31));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 0, 0, 0, 1, FOPMUL, 5'd31));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(1, 0, 0, 0, 1, FOPMUL, 5'd31));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 1, 1, 1, FOPMUL, 5'd31));
        addv(0, 0, 5'd0, 5'd0, 0, 0, E(0, 0, 0, 0, 0, FOPMUL, 5'd31));

        // Two reset cycles before the table
        @(posedge iCLK);
        @(posedge iCLK);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].st, vecs[i].op, vecs[i].rd, vecs[i].wfp, vecs[i].wint);
            chk("table", i, 32'(outs()), 32'(vecs[i].exp));
        end

        // FOPDIV with iStart held and the op changed to FOPMUL at c4:
        // single issue at c1, write at c11, the held FOPMUL is accepted at c12
        // and runs to its own write at c16.
        for (int c = 0; c <= 16; c++) begin
            logic        s, st, fw, b;
            logic [4:0]  eop, erd;
            cyc(0, (c <= 12), (c < 4) ? FOPDIV : FOPMUL, 5'd12, 1, 0);
            s   = (c <= 10) || (c >= 12 && c <= 15);
            st  = (c == 1) || (c == 13);
            fw  = (c == 11) || (c == 16);
            b   = (c >= 1 && c <= 11) || (c >= 13 && c <= 16);
            eop = (c == 0) ? FOPMUL : ((c <= 12) ? FOPDIV : FOPMUL);
            erd = (c == 0) ? 5'd31 : 5'd12;
            chk("div_held", c, 32'(outs()), 32'(E(s, st, fw, 1'b0, b, eop, erd)));
        end

        // FOPSQRT aborted by reset at c5: all outputs 0 at c6, no write through c20
        writes = 0;
        for (int c = 0; c <= 20; c++) begin
            cyc((c == 5), (c == 0), FOPSQRT, 5'd5, 1, 0);
            if (c == 1) chk("sqrt_issue", c, 32'(outs()), 32'(E(1, 1, 0, 0, 1, FOPSQRT, 5'd5)));
            if (c == 6) chk("sqrt_reset", c, 32'(outs()), 32'(E(0, 0, 0, 0, 0, 5'd0, 5'd0)));
            if (c >= 6 && (oFPRegWrite || oRegWrite)) writes++;
        end
        chk("sqrt_abort_writes", 0, 32'(writes), 32'd0);

`ifdef FPSEQ_PERF_CNT_EN
        // FOPADD then FOPMUL back-to-back after a reset: 2 ops, 5+4 stall cycles
        cyc(1, 0, 5'd0, 5'd0, 0, 0);
        for (int c = 0; c <= 11; c++) begin
            cyc(0, (c == 0) || (c == 6), (c == 0) ? FOPADD : FOPMUL, 5'd1, 1, 0);
            if (c == 0) begin
                chk("perf_ops_rst", c, oOpCount, 32'd0);
                chk("perf_stall_rst", c, oStallCycles, 32'd0);
            end
            if (c == 11) begin
                chk("perf_ops", c, oOpCount, 32'd2);
                chk("perf_stall", c, oStallCycles, 32'd9);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
